id_ex_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/fwd_mux.sv | 45 ++++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the operand-issue stage and the ALU.
//   - ALU opcode constants (5-bit encoding, ADD = 0 ... MUL = 16)
//   - Default datapath / register-address widths
//   - opSel_t: per-instruction operand-select controls
package alu_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_ADDU  = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_SUBU  = 5'b00011;
  localparam logic [4:0] ALU_AND   = 5'b00100;
  localparam logic [4:0] ALU_OR    = 5'b00101;
  localparam logic [4:0] ALU_XOR   = 5'b00110;
  localparam logic [4:0] ALU_NOR   = 5'b00111;
  localparam logic [4:0] ALU_SLT   = 5'b01000;
  localparam logic [4:0] ALU_SLTU  = 5'b01001;
  localparam logic [4:0] ALU_SLL   = 5'b01010;
  localparam logic [4:0] ALU_SRL   = 5'b01011;
  localparam logic [4:0] ALU_SRA   = 5'b01100;
  localparam logic [4:0] ALU_LUI   = 5'b01101;
  localparam logic [4:0] ALU_MULH  = 5'b01110;
  localparam logic [4:0] ALU_MULHU = 5'b01111;
  localparam logic [4:0] ALU_MUL   = 5'b10000;

  // Operand-select controls carried with a decoded instruction.
  typedef struct packed {
    logic useImm;    // B takes the extended immediate
    logic immSign;   // immediate is sign-extended (else zero-extended)
    logic useShamt;  // A takes the zero-extended shift amount
  } opSel_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: resolves one source register operand.
//   Priority: r0 reads as zero, then a non-load EX result, then the MEM
//   result, then the register-file value.
// Ports:
//   srcAddr/rfVal            source register and its register-file data
//   exEn/exLoad/exAddr/exData EX-stage result (loads are not forwardable)
//   memEn/memAddr/memData     MEM-stage result
//   fwdVal                    resolved operand
module fwd_mux
  import alu_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic [RW-1:0] srcAddr,
  input  logic [DW-1:0] rfVal,
  input  logic          exEn,
  input  logic          exLoad,
  input  logic [RW-1:0] exAddr,
  input  logic [DW-1:0] exData,
  input  logic          memEn,
  input  logic [RW-1:0] memAddr,
  input  logic [DW-1:0] memData,
  output logic [DW-1:0] fwdVal
);

  logic exHit;
  logic memHit;

  // A load in EX has no data yet; the stage stalls on it instead.
  assign exHit  = exEn & !exLoad & (exAddr == srcAddr);
  assign memHit = memEn & (memAddr == srcAddr);

  always_comb begin
    fwdVal = rfVal;
    if (srcAddr == '0) begin
      fwdVal = '0;
    end else if (exHit) begin
      fwdVal = exData;
    end else if (memHit) begin
      fwdVal = memData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: registered operand-issue stage in front of the ALU.
//   Captures one decoded instruction per cycle, resolves rs/rt through EX/MEM
//   forwarding, selects immediate/shamt operands and presents a stable
//   alu_op/alu_a/alu_b triple under valid/ready. Load-use hazards stall
//   decode; flush kills the held entry and blocks capture.
// Ports:
//   clk, rst (async, active-high)
//   in_*          decode-side instruction and valid/ready handshake
//   flush         synchronous kill
//   fwd_ex_*      EX result (en, load flag, addr, data)
//   fwd_mem_*     MEM result (en, addr, data)
//   out_valid/out_ready, alu_op, alu_a, alu_b, out_rd, out_wb_en  ALU side
// Optional feature (macro ID_EX_PERF_CNT_EN):
//   perf_stall_cnt  cycles with in_valid & hazard (saturating)
//   perf_flush_cnt  flushes that killed a valid entry (saturating)
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_aluop,
  input  logic [RW-1:0] in_rs_addr,
  input  logic [RW-1:0] in_rt_addr,
  input  logic [RW-1:0] in_rd_addr,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  input  logic [15:0]   in_imm,
  input  logic          in_imm_sign,
  input  logic          in_use_imm,
  input  logic [4:0]    in_shamt,
  input  logic          in_use_shamt,
  input  logic          in_wb_en,
  input  logic          flush,
  input  logic          fwd_ex_en,
  input  logic          fwd_ex_load,
  input  logic [RW-1:0] fwd_ex_addr,
  input  logic [DW-1:0] fwd_ex_data,
  input  logic          fwd_mem_en,
  input  logic [RW-1:0] fwd_mem_addr,
  input  logic [DW-1:0] fwd_mem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [RW-1:0] out_rd,
  output logic          out_wb_en
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [DW-1:0] perf_stall_cnt,
  output logic [DW-1:0] perf_flush_cnt
`endif
);

  opSel_t        sel;
  logic [DW-1:0] rsFwd;
  logic [DW-1:0] rtFwd;
  logic [DW-1:0] immExt;
  logic [DW-1:0] aNext;
  logic [DW-1:0] bNext;
  logic          hazard;
  logic          accept;

  assign sel.useImm   = in_use_imm;
  assign sel.immSign  = in_imm_sign;
  assign sel.useShamt = in_use_shamt;

  fwd_mux #(.DW(DW), .RW(RW)) rsMux (
    .srcAddr (in_rs_addr),
    .rfVal   (in_rs_val),
    .exEn    (fwd_ex_en),
    .exLoad  (fwd_ex_load),
    .exAddr  (fwd_ex_addr),
    .exData  (fwd_ex_data),
    .memEn   (fwd_mem_en),
    .memAddr (fwd_mem_addr),
    .memData (fwd_mem_data),
    .fwdVal  (rsFwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) rtMux (
    .srcAddr (in_rt_addr),
    .rfVal   (in_rt_val),
    .exEn    (fwd_ex_en),
    .exLoad  (fwd_ex_load),
    .exAddr  (fwd_ex_addr),
    .exData  (fwd_ex_data),
    .memEn   (fwd_mem_en),
    .memAddr (fwd_mem_addr),
    .memData (fwd_mem_data),
    .fwdVal  (rtFwd)
  );

  // Load in EX whose target feeds an operand this instruction actually uses.
  // One cycle later the load sits in MEM and the MEM path supplies the data.
  assign hazard = fwd_ex_en & fwd_ex_load & (fwd_ex_addr != '0) &
                  (((fwd_ex_addr == in_rs_addr) & !sel.useShamt) |
                   ((fwd_ex_addr == in_rt_addr) & !sel.useImm));

  assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;

  assign immExt = sel.immSign ? {{(DW-16){in_imm[15]}}, in_imm}
                              : {{(DW-16){1'b0}}, in_imm};
  assign aNext  = sel.useShamt ? {{(DW-5){1'b0}}, in_shamt} : rsFwd;
  assign bNext  = sel.useImm ? immExt : rtFwd;

  // Data registers only move on accept, so a consumed or flushed entry keeps
  // its last values on the outputs with out_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_rd    <= '0;
      out_wb_en <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_op    <= in_aluop;
      alu_a     <= aNext;
      alu_b     <= bNext;
      out_rd    <= in_rd_addr;
      out_wb_en <= in_wb_en;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (in_valid & hazard & (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
      if (flush & out_valid & (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan cases plus randomized traffic, each cycle
// checked against a behavioural model of the stage kept in the bench.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_aluop;
  logic [RW-1:0] in_rs_addr, in_rt_addr, in_rd_addr;
  logic [DW-1:0] in_rs_val, in_rt_val;
  logic [15:0]   in_imm;
  logic          in_imm_sign, in_use_imm;
  logic [4:0]    in_shamt;
  logic          in_use_shamt, in_wb_en, flush;
  logic          fwd_ex_en, fwd_ex_load;
  logic [RW-1:0] fwd_ex_addr;
  logic [DW-1:0] fwd_ex_data;
  logic          fwd_mem_en;
  logic [RW-1:0] fwd_mem_addr;
  logic [DW-1:0] fwd_mem_data;
  logic          out_valid, out_ready;
  logic [4:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic [RW-1:0] out_rd;
  logic          out_wb_en;
`ifdef ID_EX_PERF_CNT_EN
  logic [DW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_imm_sign(in_imm_sign), .in_use_imm(in_use_imm),
    .in_shamt(in_shamt), .in_use_shamt(in_use_shamt), .in_wb_en(in_wb_en),
    .flush(flush),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_load(fwd_ex_load),
    .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .out_rd(out_rd), .out_wb_en(out_wb_en)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errCount = 0;
  int checkCount = 0;
  int stepNum = 0;
  logic readySeen;

  // Reference model state: the entry the stage should be presenting.
  logic          mValid;
  logic [4:0]    mOp;
  logic [DW-1:0] mA, mB;
  logic [RW-1:0] mRd;
  logic          mWb;
  longint        mStalls, mFlushes;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (step %0d)", tag, got, exp, stepNum);
    end
  endtask

  // Operand value a source register should resolve to.
  function automatic logic [DW-1:0] resolve(input logic [RW-1:0] r, input logic [DW-1:0] rf);
    if (r == 0) return '0;
    if (fwd_ex_en && !fwd_ex_load && fwd_ex_addr == r) return fwd_ex_data;
    if (fwd_mem_en && fwd_mem_addr == r) return fwd_mem_data;
    return rf;
  endfunction

  // True when a load in EX targets a register the incoming instruction reads.
  function automatic bit loadUse();
    bit rsRead, rtRead;
    if (!(fwd_ex_en && fwd_ex_load) || fwd_ex_addr == 0) return 0;
    rsRead = !in_use_shamt && in_rs_addr == fwd_ex_addr;
    rtRead = !in_use_imm && in_rt_addr == fwd_ex_addr;
    return rsRead || rtRead;
  endfunction

  task automatic modelReset();
    mValid = 0; mOp = 0; mA = 0; mB = 0; mRd = 0; mWb = 0;
    mStalls = 0; mFlushes = 0;
  endtask

  task automatic clearInputs();
    in_valid = 0; in_aluop = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
    in_rs_val = 0; in_rt_val = 0; in_imm = 0; in_imm_sign = 0; in_use_imm = 0;
    in_shamt = 0; in_use_shamt = 0; in_wb_en = 0; flush = 0;
    fwd_ex_en = 0; fwd_ex_load = 0; fwd_ex_addr = 0; fwd_ex_data = 0;
    fwd_mem_en = 0; fwd_mem_addr = 0; fwd_mem_data = 0; out_ready = 1;
  endtask

  task automatic checkOutputs();
    checkEq("out_valid", out_valid, mValid);
    if (mValid) begin
      checkEq("alu_op", alu_op, mOp);
      checkEq("alu_a", alu_a, mA);
      checkEq("alu_b", alu_b, mB);
      checkEq("out_rd", out_rd, mRd);
      checkEq("out_wb_en", out_wb_en, mWb);
    end
`ifdef ID_EX_PERF_CNT_EN
    checkEq("perf_stall_cnt", perf_stall_cnt, mStalls);
    checkEq("perf_flush_cnt", perf_flush_cnt, mFlushes);
`endif
  endtask

  // One clock cycle: inputs were set at the falling edge by the caller.
  task automatic step();
    bit hz, rdy, take;
    logic [DW-1:0] a, b, imm;
    stepNum++;
    #1;
    hz  = loadUse();
    rdy = (!mValid || out_ready) && !hz && !flush;
    readySeen = in_ready;
    checkEq("in_ready", in_ready, rdy);
    take = in_valid && rdy;
    imm = in_imm_sign ? DW'(signed'(in_imm)) : DW'(in_imm);
    a = in_use_shamt ? DW'(in_shamt) : resolve(in_rs_addr, in_rs_val);
    b = in_use_imm ? imm : resolve(in_rt_addr, in_rt_val);
    if (in_valid && hz) mStalls++;
    if (flush && mValid) mFlushes++;
    @(posedge clk);
    if (flush) mValid = 0;
    else if (take) begin
      mValid = 1; mOp = in_aluop; mA = a; mB = b; mRd = in_rd_addr; mWb = in_wb_en;
    end else if (mValid && out_ready) mValid = 0;
    #1;
    checkOutputs();
    $display("step %0d: in_v=%0b rdy=%0b flush=%0b hz=%0b -> out_v=%0b op=%0d a=0x%0h b=0x%0h",
             stepNum, in_valid, rdy, flush, hz, out_valid, alu_op, alu_a, alu_b);
    @(negedge clk);
  endtask

  task automatic setAdd(input logic [RW-1:0] rs, input logic [DW-1:0] rsv,
                        input logic [RW-1:0] rt, input logic [DW-1:0] rtv);
    in_valid = 1; in_aluop = 5'b00000; in_rs_addr = rs; in_rs_val = rsv;
    in_rt_addr = rt; in_rt_val = rtv; in_rd_addr = 5'd3; in_wb_en = 1;
    in_use_imm = 0; in_use_shamt = 0;
  endtask

  logic [DW-1:0] holdA, holdB;

  initial begin
    clearInputs();
    modelReset();
    rst = 1;
    #12;
    // Reset state: outputs cleared, in_ready high with no hazard/flush.
    checkEq("rst_out_valid", out_valid, 0);
    checkEq("rst_alu_a", alu_a, 0);
    checkEq("rst_alu_b", alu_b, 0);
    checkEq("rst_alu_op", alu_op, 0);
    checkEq("rst_out_rd", out_rd, 0);
    checkEq("rst_wb_en", out_wb_en, 0);
    checkEq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Plain ADD r1(5) + r2(7).
    setAdd(1, 5, 2, 7);
    step();
    checkEq("add_a", alu_a, 5);
    checkEq("add_b", alu_b, 7);
    checkEq("add_op", alu_op, 0);

    // EX and MEM both write r1: EX wins.
    setAdd(1, 5, 2, 7);
    fwd_ex_en = 1; fwd_ex_addr = 1; fwd_ex_data = 32'h10;
    fwd_mem_en = 1; fwd_mem_addr = 1; fwd_mem_data = 32'h20;
    step();
    checkEq("fwd_ex_prio", alu_a, 32'h10);
    // Same, targeting r0: reads as zero.
    setAdd(0, 5, 2, 7);
    fwd_ex_addr = 0; fwd_mem_addr = 0;
    step();
    checkEq("fwd_r0", alu_a, 0);
    clearInputs();

    // Load-use on rt = r2: one bubble, then MEM supplies the data.
    setAdd(1, 5, 2, 7);
    fwd_ex_en = 1; fwd_ex_load = 1; fwd_ex_addr = 2; fwd_ex_data = 32'hDEAD;
    step();
    checkEq("hazard_ready", readySeen, 0);
    fwd_ex_en = 0; fwd_ex_load = 0;
    fwd_mem_en = 1; fwd_mem_addr = 2; fwd_mem_data = 32'hABCD;
    step();
    checkEq("hazard_clear_ready", readySeen, 1);
    checkEq("hazard_mem_b", alu_b, 32'hABCD);
    clearInputs();

    // Immediates and shift amount.
    setAdd(1, 5, 2, 7);
    in_use_imm = 1; in_imm = 16'h8000; in_imm_sign = 1;
    step();
    checkEq("imm_sext", alu_b, 32'hFFFF8000);
    in_imm_sign = 0;
    step();
    checkEq("imm_zext", alu_b, 32'h00008000);
    in_aluop = 5'b01010; in_use_shamt = 1; in_shamt = 3;
    step();
    checkEq("shamt_a", alu_a, 3);
    clearInputs();

    // Backpressure: hold 4 cycles, then release.
    setAdd(1, 11, 2, 22);
    step();
    holdA = alu_a; holdB = alu_b;
    setAdd(1, 33, 2, 44);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkEq("bp_ready", readySeen, 0);
      checkEq("bp_hold_a", alu_a, holdA);
      checkEq("bp_hold_b", alu_b, holdB);
    end
    out_ready = 1;
    step();
    checkEq("bp_next_a", alu_a, 33);
    clearInputs();

    // Flush with in_valid while an entry is held.
    setAdd(1, 1, 2, 2);
    out_ready = 0;
    step();
    flush = 1;
    setAdd(1, 9, 2, 9);
    step();
    checkEq("flush_valid", out_valid, 0);
`ifdef ID_EX_PERF_CNT_EN
    checkEq("flush_cnt", perf_flush_cnt, 1);
`endif
    clearInputs();

    // Randomized traffic with small register indices to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_aluop     = 5'($urandom_range(0, 16));
      in_rs_addr   = RW'($urandom_range(0, 3));
      in_rt_addr   = RW'($urandom_range(0, 3));
      in_rd_addr   = RW'($urandom_range(0, 31));
      in_rs_val    = $urandom;
      in_rt_val    = $urandom;
      in_imm       = 16'($urandom);
      in_imm_sign  = 1'($urandom);
      in_use_imm   = ($urandom_range(0, 3) == 0);
      in_shamt     = 5'($urandom);
      in_use_shamt = ($urandom_range(0, 5) == 0);
      in_wb_en     = 1'($urandom);
      flush        = ($urandom_range(0, 9) == 0);
      fwd_ex_en    = 1'($urandom);
      fwd_ex_load  = ($urandom_range(0, 2) == 0);
      fwd_ex_addr  = RW'($urandom_range(0, 3));
      fwd_ex_data  = $urandom;
      fwd_mem_en   = 1'($urandom);
      fwd_mem_addr = RW'($urandom_range(0, 3));
      fwd_mem_data = $urandom;
      out_ready    = ($urandom_range(0, 3) != 0);
      step();
    end
    clearInputs();

    // Asynchronous reset mid-operation drops the entry at once.
    setAdd(1, 3, 2, 4);
    out_ready = 0;
    step();
    #2;
    rst = 1;
    #1;
    checkEq("async_rst_valid", out_valid, 0);
    checkEq("async_rst_a", alu_a, 0);
    modelReset();
    clearInputs();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    step();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
